mul_div_seq: RTL
================

Name: mul_div_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit producing HI/LO results for the datapath's MULTI/DIV instructions.
- Replaces the single-cycle combinational mul/div path feeding ZHigh/ZLow.
- Adds a start/busy/done handshake, a signed/unsigned mode, configurable width and divide-by-zero reporting.
- Sits beside the ALU; its hi_out/lo_out feed the HI/LO registers.

Parameters:
- WIDTH, 32, operand and result-half width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Clear  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op_code  input  5  5'b01100=MULTI, 5'b01101=DIV; any other value ignores start.
- is_signed  input  1  1=two's-complement operands, 0=unsigned; captured with start.
- operand_a  input  WIDTH  multiplicand / dividend; captured with start.
- operand_b  input  WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high from the accept edge until results are written.
- done  output  1  one-cycle pulse; hi_out/lo_out valid in that cycle.
- div_by_zero  output  1  set with results of a DIV whose divisor is 0; cleared on the next accept.
- hi_out  output  WIDTH  MULTI: upper product half; DIV: remainder.
- lo_out  output  WIDTH  MULTI: lower product half; DIV: quotient.

Behaviour:
- Reset (Clear=0, any time, including mid-operation):
  - State = IDLE; busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0.
  - All internal registers cleared; no partial result is ever exposed.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with a valid op_code at edge E0 → capture operation, sign flags and operand magnitudes (|x| when is_signed and MSB=1, else raw); counter=WIDTH; busy=1; go to CALC.
  - DIV with operand_b=0 → go straight to FIX and set the divide-by-zero path instead.
  - done is driven 0 on any edge that does not write results.
- CALC:
  - One radix-2 step per edge; counter decrements; leave for FIX when the counter reaches 1 → WIDTH edges (E1..E_WIDTH).
  - MULTI: shift-add on a 2*WIDTH unsigned accumulator.
  - DIV: restoring division on magnitudes.
- FIX (edge E_WIDTH+1):
  - Apply signs:
    - product negated when sign_a XOR sign_b;
    - quotient negated when sign_a XOR sign_b;
    - remainder takes the sign of the dividend.
  - Write hi_out/lo_out; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH+1 (33 edges for WIDTH=32). Divide-by-zero: done after E1.
- Back-to-back: start may be accepted in the same cycle that done=1. The new accept drops done and clears div_by_zero.
- start while busy=1: ignored, not queued. Operand/mode changes while busy have no effect.
- hi_out/lo_out hold their values until the next FIX or reset.
- Divide by zero: lo_out = all ones, hi_out = operand_a unchanged, div_by_zero=1.
- Signed DIV of most-negative / -1: lo_out = 1 followed by WIDTH-1 zeros, hi_out=0; no flag raised.
- Arithmetic widths:
  - Magnitudes are WIDTH-bit unsigned; the 2^(WIDTH-1) magnitude is representable.
  - Product accumulator is 2*WIDTH bits; the divider partial remainder is WIDTH+1 bits.

Decomposition:
- Shared package:
  - op-code constants MULTI=5'b01100 and DIV=5'b01101, shared with the control unit and testbenches;
  - state encoding IDLE/CALC/FIX.
- One natural sub-module: mul_div_step.
  - Combinational single-iteration datapath: either the shift-add or the restore/subtract step, selected by op.
  - Instantiated once inside the sequencer.

Test Plan:
- Unsigned MULTI, a=1637, b=5877 → done at edge E33, lo_out=32'h0092CCA9, hi_out=0, busy low after done.
- Unsigned DIV, a=5877, b=1637 → lo_out=3, hi_out=966, div_by_zero=0.
- Signed: MULTI -7×3 → lo=32'hFFFFFFEB, hi=32'hFFFFFFFF. DIV -7/2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000/-1 → lo=32'h80000000, hi=0.
- Unsigned MULTI 32'hFFFFFFFF×32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. The same operands with is_signed=1 → hi=0, lo=1.
- DIV 100/0 → done after E1, lo=32'hFFFFFFFF, hi=100, div_by_zero=1. The next accepted MULTI clears the flag.
- Clear pulsed low at edge E10 of a DIV → all outputs 0 immediately, IDLE. start held high during busy and an invalid op_code (5'b00000) both produce no done pulse.

Source files
------------

// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: the
// instruction op-codes it recognises and the sequencer state encoding.
package mul_div_seq_pkg;

    // Op-codes shared with the control unit and benches
    localparam logic [4:0] MULTI = 5'b01100;
    localparam logic [4:0] DIV   = 5'b01101;

    // Sequencer states: waiting, iterating, applying signs / writing results
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // True for the op-codes this unit executes; anything else ignores start
    function automatic logic is_valid_op(input logic [4:0] op);
        return (op == MULTI) || (op == DIV);
    endfunction

endpackage

// File: rtl/mul_div_seq_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on a 2*WIDTH accumulator whose low half starts as the
// multiplier magnitude. Divide: restoring step where the low accumulator half
// shifts the dividend out at the top and the quotient bits in at the bottom,
// while rem carries the partial remainder.
module mul_div_seq_step
    import mul_div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     rem_in,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   acc_out,
    output logic [WIDTH-1:0]     rem_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // Select and compute the single iteration for the active operation
    always_comb begin
        acc_out = acc_in;
        rem_out = rem_in;
        sum     = '0;
        trial   = '0;
        diff    = '0;
        if (!is_div) begin
            sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
            if (acc_in[0]) begin
                acc_out = {sum, acc_in[WIDTH-1:1]};
            end else begin
                acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
            end
        end else begin
            trial = {rem_in, acc_in[WIDTH-1]};
            diff  = trial[WIDTH-1:0] - mag_b;
            if (trial >= {1'b0, mag_b}) begin
                rem_out = diff;
                acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                rem_out = trial[WIDTH-1:0];
                acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle multiply/divide unit feeding the HI/LO registers.
// Operands are captured as magnitudes on accept, WIDTH iterations run on the
// shared step datapath, and a final FIX cycle applies the signs and writes
// hi_out/lo_out together with a one-cycle done pulse.
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [4:0]       op_code,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic               dbz_pending;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;

    logic               in_sign_a;
    logic               in_sign_b;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   step_rem;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    // Operand magnitudes and signs as they would be captured on accept
    always_comb begin
        in_sign_a = is_signed & operand_a[WIDTH-1];
        in_sign_b = is_signed & operand_b[WIDTH-1];
        in_mag_a  = in_sign_a ? (~operand_a + 1'b1) : operand_a;
        in_mag_b  = in_sign_b ? (~operand_b + 1'b1) : operand_b;
    end

    mul_div_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (op_div),
        .acc_in  (acc),
        .rem_in  (rem),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .acc_out (step_acc),
        .rem_out (step_rem)
    );

    // Signed results from the finished magnitudes; remainder follows the dividend
    always_comb begin
        product   = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        quotient  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        remainder = sign_a ? (~rem + 1'b1) : rem;
    end

    // Sequencer: accept, iterate WIDTH times, then fix signs and write results
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state       <= IDLE;
            op_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dbz_pending <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            rem         <= '0;
            acc         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_valid_op(op_code)) begin
                        op_div      <= (op_code == DIV);
                        sign_a      <= in_sign_a;
                        sign_b      <= in_sign_b;
                        mag_a       <= in_mag_a;
                        mag_b       <= in_mag_b;
                        rem         <= '0;
                        count       <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if ((op_code == DIV) && (operand_b == '0)) begin
                            dbz_pending <= 1'b1;
                            acc         <= {{WIDTH{1'b0}}, operand_a};
                            state       <= FIX;
                        end else begin
                            dbz_pending <= 1'b0;
                            acc         <= (op_code == DIV) ? {{WIDTH{1'b0}}, in_mag_a}
                                                            : {{WIDTH{1'b0}}, in_mag_b};
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= step_acc;
                    rem   <= step_rem;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_pending) begin
                        hi_out      <= acc[WIDTH-1:0];
                        lo_out      <= '1;
                        div_by_zero <= 1'b1;
                    end else if (op_div) begin
                        hi_out <= remainder;
                        lo_out <= quotient;
                    end else begin
                        hi_out <= product[2*WIDTH-1:WIDTH];
                        lo_out <= product[WIDTH-1:0];
                    end
                    dbz_pending <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
